instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//   Instruction fetch and instruction register for the toy processor.
//   - Reads one 16-bit instruction as two 8-bit bytes from byte-wide program memory.
//   - The first byte is read at the address on pc_addr; the second byte at pc_addr+1.
//   - Presents the result as opcode and ir_addr.
//   - Produces pc_inc for each byte consumed, and pc_load for a jump. Both feed the program counter.
// PARAMETERS
//   ADDR_W  13      address width; matches the program counter width
//   DATA_W  8       memory byte width
//   OP_W    3       opcode width; the 16-bit instruction is {opcode, ir_addr}
//   JMP_OP  3'b111  opcode value that asserts pc_load
// PORTS
//   clk       in   1       system clock; all state changes on its rising edge
//   rst_n     in   1       asynchronous, active-low reset
//   pc_addr   in   ADDR_W  current program counter value
//   fetch_en  in   1       request to fetch one instruction; sampled only in IDLE
//   mem_rd    out  1       memory read request; held high until mem_ack
//   mem_addr  out  ADDR_W  memory byte address; stable while mem_rd is high
//   mem_data  in   DATA_W  read data; valid in the cycle mem_ack is high
//   mem_ack   in   1       read complete; honoured only while mem_rd is high
//   pc_inc    out  1       one-cycle pulse per byte consumed (counter increment enable)
//   pc_load   out  1       one-cycle pulse, coincident with ir_valid, when opcode==JMP_OP
//   ir_valid  out  1       one-cycle pulse: opcode and ir_addr hold a new instruction
//   opcode    out  OP_W    instruction bits [15:13]
//   ir_addr   out  ADDR_W  instruction bits [12:0]; drives the counter's load address
//   busy      out  1       high in every state except IDLE
// BEHAVIOUR
//   Reset (rst_n low, asynchronous):
//   - State goes to IDLE immediately.
//   - All outputs read 0, including opcode, ir_addr and mem_addr.
//   - The internal base address and high-byte register are cleared.
//   - Reset mid-fetch aborts the fetch: no pc_inc, no ir_valid, and opcode/ir_addr are not updated.
//   FSM states: IDLE, RD_HI, RD_LO, DONE. All outputs are registered.
//   - IDLE: on fetch_en=1, latch base<=pc_addr and go to RD_HI.
//     mem_rd=1 and mem_addr=base from the next cycle.
//   - RD_HI: hold mem_rd=1, mem_addr=base.
//     On the edge where mem_ack=1: hi<=mem_data, pc_inc=1 for the next cycle, go to RD_LO.
//     mem_addr=base+1 from the next cycle.
//     mem_rd stays high across the transition; no idle cycle between the two bytes.
//   - RD_LO: hold mem_rd=1, mem_addr=base+1.
//     On mem_ack=1: go to DONE and update opcode<=hi[7:5], ir_addr<={hi[4:0],mem_data}.
//     mem_rd falls and pc_inc=1 for the next cycle.
//   - DONE: ir_valid=1 for exactly one cycle; pc_load=1 in the same cycle if opcode==JMP_OP.
//     Always returns to IDLE, so pc_addr has settled before the next latch.
//   Latency: fetch_en sampled -> ir_valid = 3 + (wait cycles on byte 0) + (wait cycles on byte 1).
//   - Zero-wait memory gives 3 cycles.
//   - Zero-wait memory means mem_ack=1 in the first cycle mem_rd is high.
//   - Minimum spacing between ir_valid pulses is 4 cycles.
//   Arithmetic: base+1 is ADDR_W-bit modulo; 13'h1FFF wraps to 13'h0000.
//   The block never reads pc_addr outside IDLE.
//   opcode and ir_addr hold their value until the next DONE.
//   Ignored inputs and boundary cases:
//   - mem_ack outside RD_HI/RD_LO is ignored.
//   - fetch_en outside IDLE is ignored; no queuing.
//   - fetch_en held high gives back-to-back fetches, one every 4+ cycles.
//   - mem_ack on the same edge mem_rd first rises is legal.
//   - The block does not time out; it waits for mem_ack indefinitely.
// TESTING
//   1. Reset: drive rst_n low mid-RD_LO.
//      -> All outputs 0 asynchronously; state IDLE; no ir_valid after rst_n returns high.
//   2. Zero-wait fetch: pc_addr=13'h0010, memory[0x10]=8'h4A, [0x11]=8'h5C, fetch_en pulse.
//      -> mem_addr 0x10 then 0x11, two pc_inc pulses.
//      -> ir_valid 3 cycles after fetch_en with opcode=3'b010, ir_addr=13'h0A5C, pc_load=0.
//   3. Wait states: 2-cycle ack delay on byte 0 and 1-cycle delay on byte 1.
//      -> mem_addr and mem_rd stable throughout each wait; ir_valid at cycle 6; exactly 2 pc_inc.
//   4. Jump: memory[0x20]=8'hE1, [0x21]=8'h00.
//      -> opcode=3'b111, ir_addr=13'h0100, pc_load and ir_valid high in the same single cycle.
//   5. Wrap: pc_addr=13'h1FFF.
//      -> Second read at mem_addr=13'h0000; instruction assembled from bytes [0x1FFF] and [0x0000].
//   6. Spurious inputs: mem_ack pulses in IDLE, and fetch_en pulses during RD_HI.
//      -> No state change, no pc_inc, no extra fetch.
//      -> fetch_en held high with a model PC incrementing on pc_inc: one fetch every 4 cycles at 0x00, 0x02, 0x04.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch and instruction register: reads a 16-bit instruction as two
// bytes (pc_addr, pc_addr+1) from byte-wide memory and presents opcode/ir_addr.
module instr_fetch #(
   parameter int unsigned      ADDR_W = 13,
   parameter int unsigned      DATA_W = 8,
   parameter int unsigned      OP_W   = 3,
   parameter logic [OP_W-1:0]  JMP_OP = 3'b111
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] pc_addr,
   input  logic              fetch_en,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              mem_ack,
   output logic              pc_inc,
   output logic              pc_load,
   output logic              ir_valid,
   output logic [OP_W-1:0]   opcode,
   output logic [ADDR_W-1:0] ir_addr,
   output logic              busy
);

   localparam int unsigned LO_W = DATA_W - OP_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_HI = 2'd1,
      RD_LO = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   base;
   logic [DATA_W-1:0]   hi;

   // Fetch sequencer; every output is a register updated here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         base     <= '0;
         hi       <= '0;
         mem_rd   <= 1'b0;
         mem_addr <= '0;
         pc_inc   <= 1'b0;
         pc_load  <= 1'b0;
         ir_valid <= 1'b0;
         opcode   <= '0;
         ir_addr  <= '0;
         busy     <= 1'b0;
      end else begin
         pc_inc   <= 1'b0;
         pc_load  <= 1'b0;
         ir_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (fetch_en) begin
                  base     <= pc_addr;
                  mem_addr <= pc_addr;
                  mem_rd   <= 1'b1;
                  busy     <= 1'b1;
                  state    <= RD_HI;
               end
            end
            RD_HI: begin
               // mem_rd stays high so the second byte is requested with no gap
               if (mem_ack) begin
                  hi       <= mem_data;
                  pc_inc   <= 1'b1;
                  mem_addr <= base + ADDR_W'(1);
                  state    <= RD_LO;
               end
            end
            RD_LO: begin
               if (mem_ack) begin
                  opcode  <= hi[DATA_W-1 -: OP_W];
                  ir_addr <= ADDR_W'({hi[LO_W-1:0], mem_data});
                  mem_rd  <= 1'b0;
                  pc_inc  <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               // Extra cycle lets the program counter settle before the next latch
               ir_valid <= 1'b1;
               pc_load  <= (opcode == JMP_OP);
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a cycle-stepped memory responder with
// configurable wait states, plus per-scenario tasks with inline comparisons.
module tb_instr_fetch;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic [12:0] pc_addr  = '0;
   logic        fetch_en = 1'b0;
   logic        mem_rd;
   logic [12:0] mem_addr;
   logic [7:0]  mem_data = '0;
   logic        mem_ack  = 1'b0;
   logic        pc_inc;
   logic        pc_load;
   logic        ir_valid;
   logic [2:0]  opcode;
   logic [12:0] ir_addr;
   logic        busy;

   logic [7:0]  mem [0:8191];
   int          total = 0;
   int          bad   = 0;
   logic [33:0] outs;

   assign outs = {mem_rd, mem_addr, pc_inc, pc_load, ir_valid, opcode, ir_addr, busy};

   instr_fetch dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pc_addr  (pc_addr),
      .fetch_en (fetch_en),
      .mem_rd   (mem_rd),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .mem_ack  (mem_ack),
      .pc_inc   (pc_inc),
      .pc_load  (pc_load),
      .ir_valid (ir_valid),
      .opcode   (opcode),
      .ir_addr  (ir_addr),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one fetch and play memory with w0/w1 wait cycles; report what was seen
   task automatic do_fetch(input logic [12:0] pc, input int w0, input int w1, input bit spur,
                           output int lat, output int incs, output logic [2:0] op,
                           output logic [12:0] ia, output logic ld, output logic [12:0] a1,
                           output bit ok);
      int k;
      int waited;
      bit started;
      logic [12:0] want;
      lat = -1; incs = 0; op = '0; ia = '0; ld = 1'b0; a1 = '1; ok = 1'b1;
      k = 0; waited = 0; started = 1'b0;
      pc_addr  = pc;
      fetch_en = 1'b1;
      mem_ack  = 1'b0;
      tick();
      fetch_en = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (pc_inc) incs++;
         if (ir_valid) begin
            lat = cyc; op = opcode; ia = ir_addr; ld = pc_load;
            break;
         end
         if (mem_rd) started = 1'b1;
         if (started && k < 2 && !mem_rd) ok = 1'b0;
         mem_ack  = 1'b0;
         mem_data = 8'($urandom);
         fetch_en = spur && (k == 0) && (cyc % 2 == 0);
         if (mem_rd && k < 2) begin
            want = (k == 0) ? pc : pc + 13'd1;
            if (mem_addr !== want) ok = 1'b0;
            if (k == 1) a1 = mem_addr;
            if (waited == ((k == 0) ? w0 : w1)) begin
               mem_ack  = 1'b1;
               mem_data = mem[mem_addr];
               k++;
               waited = 0;
            end else begin
               waited++;
            end
         end
         tick();
      end
      mem_ack  = 1'b0;
      fetch_en = 1'b0;
   endtask

   task automatic test_reset();
      bit quiet;
      rst_n = 1'b0;
      tick();
      tick();
      total++;
      if (outs !== 34'd0) begin
         bad++;
         $display("FAIL reset.outputs got=%h want=0", outs);
      end
      rst_n = 1'b1;
      tick();
      mem[13'h0030] = 8'hFF;
      mem[13'h0031] = 8'hFF;
      pc_addr  = 13'h0030;
      fetch_en = 1'b1;
      tick();
      fetch_en = 1'b0;
      mem_ack  = 1'b1;
      mem_data = mem[13'h0030];
      tick();
      mem_ack = 1'b0;
      tick();
      total++;
      if ({busy, mem_rd, mem_addr} !== {1'b1, 1'b1, 13'h0031}) begin
         bad++;
         $display("FAIL reset.mid_rd_lo got=%b/%b/%h want=1/1/0031", busy, mem_rd, mem_addr);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (outs !== 34'd0) begin
         bad++;
         $display("FAIL reset.async_clear got=%h want=0", outs);
      end
      mem_ack  = 1'b1;
      mem_data = 8'hFF;
      @(negedge clk);
      rst_n = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (ir_valid || pc_inc || busy || mem_rd || opcode != 3'd0 || ir_addr != 13'd0)
            quiet = 1'b0;
      end
      mem_ack = 1'b0;
      total++;
      if (quiet !== 1'b1) begin
         bad++;
         $display("FAIL reset.no_resume got=activity want=quiet");
      end
   endtask

   task automatic test_zero_wait();
      int lat, incs;
      logic [2:0] op;
      logic [12:0] ia, a1;
      logic ld;
      bit ok;
      mem[13'h0010] = 8'h4A;
      mem[13'h0011] = 8'h5C;
      do_fetch(13'h0010, 0, 0, 1'b0, lat, incs, op, ia, ld, a1, ok);
      total++;
      if (lat !== 3) begin bad++; $display("FAIL zero_wait.latency got=%0d want=3", lat); end
      total++;
      if (incs !== 2) begin bad++; $display("FAIL zero_wait.pc_inc got=%0d want=2", incs); end
      total++;
      if ({op, ia, ld} !== {3'b010, 13'h0A5C, 1'b0}) begin
         bad++;
         $display("FAIL zero_wait.instr got=%b/%h/%b want=010/0a5c/0", op, ia, ld);
      end
      total++;
      if (ok !== 1'b1 || a1 !== 13'h0011) begin
         bad++;
         $display("FAIL zero_wait.addrs got=ok%0d/%h want=ok1/0011", ok, a1);
      end
      tick();
      total++;
      if ({ir_valid, busy} !== 2'b00) begin
         bad++;
         $display("FAIL zero_wait.pulse got=%b want=00", {ir_valid, busy});
      end
   endtask

   task automatic test_wait_states();
      int lat, incs;
      logic [2:0] op;
      logic [12:0] ia, a1;
      logic ld;
      bit ok;
      mem[13'h0040] = 8'h3C;
      mem[13'h0041] = 8'hA5;
      do_fetch(13'h0040, 2, 1, 1'b0, lat, incs, op, ia, ld, a1, ok);
      total++;
      if (lat !== 6) begin bad++; $display("FAIL wait.latency got=%0d want=6", lat); end
      total++;
      if (incs !== 2) begin bad++; $display("FAIL wait.pc_inc got=%0d want=2", incs); end
      total++;
      if (ok !== 1'b1) begin bad++; $display("FAIL wait.stable got=%0d want=1", ok); end
      total++;
      if ({op, ia} !== {3'b001, 13'h1CA5}) begin
         bad++;
         $display("FAIL wait.instr got=%b/%h want=001/1ca5", op, ia);
      end
   endtask

   task automatic test_jump();
      int lat, incs;
      logic [2:0] op;
      logic [12:0] ia, a1;
      logic ld;
      bit ok;
      mem[13'h0020] = 8'hE1;
      mem[13'h0021] = 8'h00;
      do_fetch(13'h0020, 0, 0, 1'b0, lat, incs, op, ia, ld, a1, ok);
      total++;
      if ({op, ia, ld} !== {3'b111, 13'h0100, 1'b1} || lat !== 3) begin
         bad++;
         $display("FAIL jump.instr got=%b/%h/ld%b/lat%0d want=111/0100/ld1/lat3", op, ia, ld, lat);
      end
      tick();
      total++;
      if ({pc_load, ir_valid, opcode, ir_addr} !== {1'b0, 1'b0, 3'b111, 13'h0100}) begin
         bad++;
         $display("FAIL jump.after got=%b/%b/%b/%h want=0/0/111/0100", pc_load, ir_valid, opcode, ir_addr);
      end
   endtask

   task automatic test_wrap();
      int lat, incs;
      logic [2:0] op;
      logic [12:0] ia, a1;
      logic ld;
      bit ok;
      mem[13'h1FFF] = 8'h6B;
      mem[13'h0000] = 8'h2D;
      do_fetch(13'h1FFF, 0, 0, 1'b0, lat, incs, op, ia, ld, a1, ok);
      total++;
      if (a1 !== 13'h0000 || ok !== 1'b1) begin
         bad++;
         $display("FAIL wrap.addr got=%h/ok%0d want=0000/ok1", a1, ok);
      end
      total++;
      if ({op, ia} !== {3'b011, 13'h0B2D}) begin
         bad++;
         $display("FAIL wrap.instr got=%b/%h want=011/0b2d", op, ia);
      end
   endtask

   task automatic test_spurious();
      int lat, incs;
      logic [2:0] op;
      logic [12:0] ia, a1;
      logic ld;
      bit quiet;
      bit ok;
      quiet   = 1'b1;
      mem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mem_ack = (i != 1);
         tick();
         if (busy || mem_rd || pc_inc || ir_valid) quiet = 1'b0;
      end
      mem_ack = 1'b0;
      total++;
      if (quiet !== 1'b1) begin bad++; $display("FAIL spurious.ack_idle got=activity want=quiet"); end
      mem[13'h0050] = 8'h87;
      mem[13'h0051] = 8'h65;
      do_fetch(13'h0050, 3, 0, 1'b1, lat, incs, op, ia, ld, a1, ok);
      total++;
      if (lat !== 6 || incs !== 2 || {op, ia} !== {3'b100, 13'h0765}) begin
         bad++;
         $display("FAIL spurious.fetch got=lat%0d/inc%0d/%b/%h want=lat6/inc2/100/0765", lat, incs, op, ia);
      end
      quiet = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (busy || mem_rd || pc_inc) quiet = 1'b0;
      end
      total++;
      if (quiet !== 1'b1) begin bad++; $display("FAIL spurious.no_extra got=fetch want=idle"); end
   endtask

   task automatic test_back_to_back();
      logic [12:0] bases [3];
      int vt [3];
      int nb, nv;
      logic [12:0] pcm, last_ia;
      bit inc_prev, rd_prev;
      nb = 0; nv = 0; pcm = '0; last_ia = '0; inc_prev = 1'b0; rd_prev = 1'b0;
      for (int i = 0; i < 3; i++) begin bases[i] = '1; vt[i] = -1; end
      mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
      mem[3] = 8'h78; mem[4] = 8'h9A; mem[5] = 8'hBC;
      pc_addr  = 13'h0000;
      fetch_en = 1'b1;
      mem_ack  = 1'b0;
      tick();
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (inc_prev) pcm = pcm + 13'd1;
         inc_prev = pc_inc;
         pc_addr  = pcm;
         if (mem_rd && !rd_prev && nb < 3) begin bases[nb] = mem_addr; nb++; end
         rd_prev = mem_rd;
         if (ir_valid && nv < 3) begin vt[nv] = cyc; nv++; last_ia = ir_addr; end
         mem_ack  = mem_rd;
         mem_data = mem_rd ? mem[mem_addr] : 8'h00;
         if (cyc == 11) fetch_en = 1'b0;
         tick();
      end
      mem_ack = 1'b0;
      total++;
      if ({bases[0], bases[1], bases[2]} !== {13'h0000, 13'h0002, 13'h0004}) begin
         bad++;
         $display("FAIL b2b.bases got=%h,%h,%h want=0000,0002,0004", bases[0], bases[1], bases[2]);
      end
      total++;
      if (vt[0] !== 3 || vt[1] !== 7 || vt[2] !== 11) begin
         bad++;
         $display("FAIL b2b.valid_cycles got=%0d,%0d,%0d want=3,7,11", vt[0], vt[1], vt[2]);
      end
      total++;
      if (last_ia !== 13'h1ABC || pcm !== 13'd6) begin
         bad++;
         $display("FAIL b2b.result got=%h/pc%0d want=1abc/pc6", last_ia, pcm);
      end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL b2b.stop got=%b want=0", busy); end
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_jump();
      test_wrap();
      test_spurious();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
